// File: rtl/shift_right_pipe_if.sv
// Valid/ready bundle for the pipelined right shifter.
// slave = shifter side, master = producer/consumer side.
interface shift_right_pipe_if #(
  parameter int WIDTH = 64,
  parameter int AMT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amt,
    input  in_arith,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output in_amt,
    output in_arith,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/shift_right_pipe.sv
// Pipelined log right shifter, one stage per amount bit, LSB first.
// Whole pipe stalls under output backpressure.
module shift_right_pipe #(
  parameter int WIDTH = 64,
  parameter int AMT_W = 6
) (
  input logic              clk,
  input logic              rst_n,
  shift_right_pipe_if.slave bus
);

  if (WIDTH != (1 << AMT_W)) begin : g_bad_params
    $error("WIDTH must equal 2**AMT_W");
  end

  // amt is kept pre-shifted so bit 0 is always the next stage's bit
  typedef struct packed {
    logic             valid;
    logic             arith;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t stage_q [AMT_W];
  stage_t stage_d [AMT_W];
  logic   adv;

  function automatic logic [WIDTH-1:0] shr(
    input logic [WIDTH-1:0] x,
    input logic             fill,
    input logic             en,
    input int               k
  );
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] res;
    mask = ~({WIDTH{1'b1}} >> (1 << k));
    res  = x;
    if (en) begin
      res = (x >> (1 << k)) | ({WIDTH{fill}} & mask);
    end
    return res;
  endfunction

  always_comb begin
    adv = !stage_q[AMT_W-1].valid || bus.out_ready;
    for (int k = 0; k < AMT_W; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (adv) begin
      stage_d[0].valid = bus.in_valid;
      stage_d[0].arith = bus.in_arith;
      stage_d[0].amt   = bus.in_amt >> 1;
      stage_d[0].data  = shr(bus.in_data,
                             bus.in_arith & bus.in_data[WIDTH-1],
                             bus.in_amt[0], 0);
      for (int k = 1; k < AMT_W; k++) begin
        stage_d[k].valid = stage_q[k-1].valid;
        stage_d[k].arith = stage_q[k-1].arith;
        stage_d[k].amt   = stage_q[k-1].amt >> 1;
        stage_d[k].data  = shr(stage_q[k-1].data,
                               stage_q[k-1].arith &
                               stage_q[k-1].data[WIDTH-1],
                               stage_q[k-1].amt[0], k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < AMT_W; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < AMT_W; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = stage_q[AMT_W-1].valid;
  assign bus.out_data  = stage_q[AMT_W-1].data;

endmodule

// File: tb/tb_shift_right_pipe.sv
// Randomized and directed checks for shift_right_pipe
// against a plain >> / >>> reference model.
module tb_shift_right_pipe;

  localparam int W  = 64;
  localparam int AW = 6;
  localparam int LAT = AW - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  logic [W-1:0] q_exp [$];
  int           q_stamp [$];

  shift_right_pipe_if #(.WIDTH(W), .AMT_W(AW)) sif ();

  shift_right_pipe #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] model(
    input logic [W-1:0] d,
    input int           amt,
    input bit           ar
  );
    logic signed [W-1:0] sd;
    sd = d;
    if (ar) return sd >>> amt;
    return d >> amt;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.in_amt    = '0;
    sif.in_arith  = 1'b0;
    sif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b want 0", sif.out_valid);
    end
    checks++;
    if (sif.out_data !== '0) begin
      failures++;
      $display("FAIL reset_out_data: got %h want 0", sif.out_data);
    end
    checks++;
    if (sif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", sif.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(
    input string        name,
    input logic [W-1:0] d,
    input int           amt,
    input bit           ar,
    input logic [W-1:0] expv
  );
    int lat;
    sif.in_valid  = 1'b1;
    sif.in_data   = d;
    sif.in_amt    = AW'(amt);
    sif.in_arith  = ar;
    sif.out_ready = 1'b1;
    #1;
    checks++;
    if (sif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready: got %b want 1", name, sif.in_ready);
    end
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    lat = 0;
    while (sif.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
    end
    checks++;
    if (sif.out_data !== expv) begin
      failures++;
      $display("FAIL %s_data: got %h want %h", name, sif.out_data, expv);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_dup: got out_valid %b want 0", name, sif.out_valid);
    end
  endtask

  task automatic test_directed();
    do_op("lsr63", 64'h8000_0000_0000_0000, 63, 1'b0, 64'h1);
    do_op("asr63", 64'h8000_0000_0000_0000, 63, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF);
    do_op("asr4", 64'h8000_0000_0000_0000, 4, 1'b1,
          64'hF800_0000_0000_0000);
    do_op("pass0", 64'h0123_4567_89AB_CDEF, 0, 1'b0,
          64'h0123_4567_89AB_CDEF);
    do_op("asrpos8", 64'h0123_4567_89AB_CDEF, 8, 1'b1,
          64'h0001_2345_6789_ABCD);
    do_op("lsr63ones", 64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b0, 64'h1);
  endtask

  // pop and compare one consumed result; optional latency check
  task automatic consume(input string tag, input bit lat_chk);
    logic [W-1:0] e;
    int           st;
    e  = q_exp.pop_front();
    st = q_stamp.pop_front();
    checks++;
    if (sif.out_data !== e) begin
      failures++;
      $display("FAIL %s_data: got %h want %h", tag, sif.out_data, e);
    end
    if (lat_chk) begin
      checks++;
      if (cyc - st != LAT) begin
        failures++;
        $display("FAIL %s_latency: got %0d want %0d", tag, cyc - st, LAT);
      end
    end
  endtask

  task automatic run_random(
    input string tag,
    input int    n,
    input int    pv,
    input int    pr,
    input bit    lat_chk
  );
    bit           acc;
    bit           stall;
    logic [W-1:0] held;
    int           amt;
    bit           ar;
    for (int i = 0; i < n; i++) begin
      amt = $urandom_range(W - 1);
      ar  = 1'($urandom_range(1));
      sif.in_valid  = ($urandom_range(99) < pv);
      sif.in_data   = rnd64();
      sif.in_amt    = AW'(amt);
      sif.in_arith  = ar;
      sif.out_ready = ($urandom_range(99) < pr);
      #1;
      checks++;
      if (sif.in_ready !== (!sif.out_valid || sif.out_ready)) begin
        failures++;
        $display("FAIL %s_in_ready: got %b want %b", tag,
                 sif.in_ready, !sif.out_valid || sif.out_ready);
      end
      acc   = sif.in_valid && (!sif.out_valid || sif.out_ready);
      stall = sif.out_valid && !sif.out_ready;
      held  = sif.out_data;
      if (sif.out_valid === 1'b1) begin
        if (q_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s_spurious: got out_valid 1 want 0", tag);
        end else if (sif.out_ready) begin
          consume(tag, lat_chk);
        end
      end
      if (acc) begin
        q_exp.push_back(model(sif.in_data, amt, ar));
        q_stamp.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
      if (stall) begin
        checks++;
        if (sif.out_valid !== 1'b1 || sif.out_data !== held) begin
          failures++;
          $display("FAIL %s_hold: got %b/%h want 1/%h", tag,
                   sif.out_valid, sif.out_data, held);
        end
      end
    end
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 50 && q_exp.size() > 0; i++) begin
      #1;
      if (sif.out_valid === 1'b1) consume(tag, lat_chk);
      @(posedge clk);
      #1;
    end
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d left want 0", tag, q_exp.size());
    end
    checks++;
    if (sif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_extra: got out_valid %b want 0", tag, sif.out_valid);
    end
    q_exp.delete();
    q_stamp.delete();
  endtask

  task automatic test_back_to_back();
    run_random("b2b", 100, 100, 100, 1'b1);
  endtask

  task automatic test_backpressure();
    run_random("bp", 300, 70, 50, 1'b0);
  endtask

  task automatic test_reset_midflight();
    int bad;
    sif.out_ready = 1'b1;
    for (int i = 0; i < AW; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data  = rnd64() | 64'h1;
      sif.in_amt   = AW'(i);
      sif.in_arith = 1'b0;
      @(posedge clk);
      #1;
    end
    sif.in_valid = 1'b0;
    checks++;
    if (sif.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_prefill: got out_valid %b want 1", sif.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sif.out_valid !== 1'b0 || sif.out_data !== '0) begin
      failures++;
      $display("FAIL mid_reset: got %b/%h want 0/0",
               sif.out_valid, sif.out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (sif.out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_stale: got %0d valid cycles want 0", bad);
    end
    do_op("mid_next", 64'hC000_0000_0000_0000, 1, 1'b1,
          64'hE000_0000_0000_0000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
